div_iter_ctrl: RTL
==================

Name: div_iter_ctrl

Overview:
- Multi-cycle integer divide sequencer in the EX stage; sits directly upstream of the CAS array logic and drives it one row per cycle.
- Accepts a divide request from the EX decoder, converts operands to magnitudes, and runs WIDTH non-restoring add/subtract steps.
- Applies remainder correction and sign fix-up, then returns quotient and remainder to EX writeback with a one-cycle valid pulse.
- Holds the pipeline stall request while the divide is in progress.

Parameters:
WIDTH, `DATA_BUS_WIDTH (32), operand/result width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_i  in  1  divide request; sampled only in IDLE
signed_i  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
dividend_i  in  WIDTH  dividend
divisor_i  in  WIDTH  divisor
flush_i  in  1  synchronous abort from pipeline control
stall_o  out  1  pipeline stall request
valid_o  out  1  result valid, one-cycle pulse
quotient_o  out  WIDTH  quotient
remainder_o  out  WIDTH  remainder

Behaviour:
- Reset is asynchronous and active-high: state=IDLE, counter=0, valid_o=0, quotient_o=0, remainder_o=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 and divisor_i==0 -> DONE; load quotient=all ones, remainder=dividend_i.
  - start_i=1 and signed_i=1 and dividend_i==0x80000000 and divisor_i==all ones (overflow) -> DONE; load quotient=dividend_i, remainder=0.
  - start_i=1 otherwise -> CALC, counter=0. Latch |dividend| and |divisor| (magnitudes only when signed_i=1), latch sign flags, clear partial remainder (WIDTH+1 bits).
- CALC: one non-restoring step per cycle.
  - Partial remainder P shifts left one bit, taking the dividend MSB.
  - P>=0 -> P-D; P<0 -> P+D.
  - The new quotient bit is the inverted sign of the new P, shifted into the quotient LSB.
  - counter increments each step; after WIDTH steps (counter==WIDTH-1 at the edge) -> FIX.
- FIX, one cycle:
  - P<0 -> P+=D.
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
  - Register results into quotient_o/remainder_o; -> DONE.
- DONE: valid_o=1 for exactly this cycle; -> IDLE unconditionally.
- quotient_o/remainder_o hold their last value until the next DONE load.
- Latency:
  - Normal divide: valid_o is high WIDTH+2 cycles after the start sampling edge (34 for WIDTH=32).
  - Zero-divisor or overflow: valid_o is high 1 cycle after the sampling edge.
- stall_o (combinational) = (IDLE & start_i) | CALC | FIX. It is low in DONE so the instruction advances with valid_o.
- start_i outside IDLE is ignored; there is no queueing.
- flush_i=1 in any state -> IDLE next edge, valid_o=0, outputs unchanged. flush_i has priority over start_i in IDLE.
- Simultaneous DONE and start_i: start is ignored, because the FSM is not in IDLE; the pipeline re-presents it.
- rst asserted mid-operation aborts immediately to the reset values; no valid pulse.
- Arithmetic widths:
  - Partial remainder is WIDTH+1 bits, two's complement.
  - Magnitude of 0x80000000 is taken as unsigned 0x80000000.

Decomposition:
- Add state encodings DIV_IDLE/DIV_CALC/DIV_FIX/DIV_DONE and the DIV_CNT_W constant to bus.v alongside `DATA_BUS_WIDTH.
- Sub-module div_step (combinational):
  - Inputs: P, D, next dividend bit.
  - Outputs: new P, quotient bit.
  - This is the single-row add/sub-control cell behaviour, instantiated once and reused each CALC cycle.
- FSM, counter, sign handling and result registers stay in div_iter_ctrl.

Test Plan:
- Unsigned 100/7 -> quotient_o=14, remainder_o=2; valid_o exactly 34 cycles after start, one cycle wide; stall_o high from start cycle through FIX.
- Signed 0xFFFFFFF9/2 (-7/2) -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF. Signed 7/0xFFFFFFFE (7/-2) -> quotient_o=0xFFFFFFFD, remainder_o=1.
- Divide by zero: 0x12345678/0, signed and unsigned -> quotient_o=0xFFFFFFFF, remainder_o=0x12345678, valid_o 1 cycle after start.
- Overflow: signed 0x80000000/0xFFFFFFFF -> quotient_o=0x80000000, remainder_o=0, 1-cycle latency. The same operands unsigned -> quotient_o=0, remainder_o=0x80000000 after 34 cycles.
- flush_i at CALC cycle 10 -> no valid_o, stall_o drops next cycle. A new start 35/5 -> quotient_o=7, remainder_o=0, with the full latency.
- Corner timing:
  - rst pulsed mid-CALC -> all outputs 0, state IDLE, no valid pulse.
  - start_i held high during CALC -> exactly one result produced.

Source files
------------

// File: rtl/div_iter_ctrl_pkg.sv
// Shared constants and state encoding for the iterative divide sequencer.
package div_iter_ctrl_pkg;

  localparam int DATA_BUS_WIDTH = 32;
  localparam int DIV_CNT_W      = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_iter_ctrl_if.sv
// Request/response bundle between the EX stage and the divide sequencer.
interface div_iter_ctrl_if
  import div_iter_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_BUS_WIDTH
) ();

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             flush_i;
  logic             stall_o;
  logic             valid_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, flush_i,
    input  stall_o, valid_o, quotient_o, remainder_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, flush_i,
    output stall_o, valid_o, quotient_o, remainder_o
  );

endinterface

// File: rtl/div_iter_ctrl_step.sv
// One non-restoring row: shift in the next dividend bit, then add or subtract
// the divisor depending on the sign of the incoming partial remainder.
module div_step
  import div_iter_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_BUS_WIDTH
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   p_o,
  output logic             q_o
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] d_ext;

  assign p_sh  = {p_i[WIDTH-1:0], bit_i};
  assign d_ext = {1'b0, d_i};
  assign p_o   = p_i[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);
  assign q_o   = ~p_o[WIDTH];

endmodule

// File: rtl/div_iter_ctrl.sv
// Multi-cycle signed/unsigned divider: magnitude non-restoring core with
// fast paths for divide-by-zero and signed overflow.
module div_iter_ctrl
  import div_iter_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_BUS_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  div_iter_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   step_p;
  logic             step_q;
  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   p_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // a_q starts as the dividend magnitude and fills with quotient bits from the LSB
  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i   (p_q),
    .d_i   (dsr_q),
    .bit_i (a_q[WIDTH-1]),
    .p_o   (step_p),
    .q_o   (step_q)
  );

  always_comb begin
    dvd_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
    dsr_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
    dvd_mag = dvd_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
    dsr_mag = dsr_neg ? (~bus.divisor_i + 1'b1) : bus.divisor_i;

    p_fix   = p_q[WIDTH] ? (p_q + {1'b0, dsr_q}) : p_q;
    quo_fix = q_neg_q ? (~a_q + 1'b1) : a_q;
    rem_fix = r_neg_q ? (~p_fix[WIDTH-1:0] + 1'b1) : p_fix[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    a_d         = a_q;
    dsr_d       = dsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = 1'b0;

    if (bus.flush_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus.start_i) begin
            if (bus.divisor_i == '0) begin
              state_d     = DIV_DONE;
              quotient_d  = '1;
              remainder_d = bus.dividend_i;
              valid_d     = 1'b1;
            end else if (bus.signed_i && bus.dividend_i == MIN_NEG && bus.divisor_i == '1) begin
              state_d     = DIV_DONE;
              quotient_d  = bus.dividend_i;
              remainder_d = '0;
              valid_d     = 1'b1;
            end else begin
              state_d = DIV_CALC;
              cnt_d   = '0;
              p_d     = '0;
              a_d     = dvd_mag;
              dsr_d   = dsr_mag;
              q_neg_d = dvd_neg ^ dsr_neg;
              r_neg_d = dvd_neg;
            end
          end
        end
        DIV_CALC: begin
          p_d   = step_p;
          a_d   = {a_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DIV_FIX;
          end
        end
        DIV_FIX: begin
          quotient_d  = quo_fix;
          remainder_d = rem_fix;
          valid_d     = 1'b1;
          state_d     = DIV_DONE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      a_q         <= '0;
      dsr_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      a_q         <= a_d;
      dsr_q       <= dsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
    end
  end

  // Stall drops in DONE so the instruction advances together with valid_o
  assign bus.stall_o     = ((state_q == DIV_IDLE) && bus.start_i) ||
                           (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign bus.valid_o     = valid_q;
  assign bus.quotient_o  = quotient_q;
  assign bus.remainder_o = remainder_q;

endmodule
